ppe_row_buffer: RTL and testbench

Clocked input stage of each PPE, directly downstream of the IFMAP memory. It accepts `OP_PPE_INPUT` row packets (25 spike bits) from the router and holds up to two rows in ping-pong buffers. It streams 5-bit sliding windows to the PPE's MAC datapath and issues `REQ_INPUT` packets back to the IFMAP memory, so the next row is prefetched while the current one streams.

---
 rtl/ppe_row_buffer.sv | 156 +++++++++++++++
 tb/tb_ppe_row_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_row_buffer.sv
// Ping-pong row buffer for one PPE: stores IFMAP rows pushed by the router,
// prefetches the next row from IFMAP memory and streams 5-bit sliding windows.
module ppe_row_buffer #(
  parameter int PE_ID       = 5,
  parameter int IMEM_ID     = 11,
  parameter int IFMAP_SIZE  = 25,
  parameter int FILTER_SIZE = 5,
  parameter int ROWS_PER_TS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pkt_in_valid,
  output logic                   pkt_in_ready,
  input  logic [32:0]            pkt_in_data,
  output logic                   pkt_out_valid,
  input  logic                   pkt_out_ready,
  output logic [32:0]            pkt_out_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [FILTER_SIZE-1:0] win_data,
  output logic [4:0]             win_col,
  output logic [2:0]             win_row,
  output logic                   ts_done,
  output logic                   pkt_drop
);

  localparam logic [4:0] LAST_COL = 5'(IFMAP_SIZE - FILTER_SIZE);
  localparam logic [3:0] OP_PPE_INPUT = 4'd1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                r_state;
  logic [IFMAP_SIZE-1:0] r_slot [2];
  logic [1:0]            r_full;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [2:0]            r_rows_rx;
  logic                  r_outstanding;
  logic                  r_pkt_out_valid;
  logic                  r_pkt_drop;
  logic [4:0]            r_win_col;
  logic [2:0]            r_win_row;

  logic       w_in_hs;
  logic       w_row_ok;
  logic       w_win_hs;
  logic       w_row_end;
  logic       w_out_hs;
  logic       w_wr_sel;
  logic [2:0] w_rows_cur;
  logic [2:0] w_rows_nxt;
  logic       w_out_nxt;
  logic [1:0] w_full_nxt;
  logic [1:0] w_pop_nxt;
  logic       w_req_cond;

  // DONE clears the timestep bookkeeping, so a row landing that cycle sees the fresh state.
  assign w_rows_cur = (r_state == S_DONE) ? 3'd0 : r_rows_rx;
  assign w_wr_sel   = (r_state == S_DONE) ? 1'b0 : r_wr_ptr;

  assign pkt_in_ready = !(r_full[0] & r_full[1]);
  assign w_in_hs   = pkt_in_valid & pkt_in_ready;
  assign w_row_ok  = w_in_hs && (pkt_in_data[32:29] == 4'(PE_ID))
                     && (pkt_in_data[28:25] == OP_PPE_INPUT)
                     && (w_rows_cur < 3'(ROWS_PER_TS));
  assign w_win_hs  = (r_state == S_STREAM) & win_ready;
  assign w_row_end = w_win_hs && (r_win_col == LAST_COL);
  assign w_out_hs  = r_pkt_out_valid & pkt_out_ready;

  assign w_rows_nxt = w_rows_cur + {2'b00, w_row_ok};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_full_nxt = r_full;
    if (w_row_end) w_full_nxt[r_rd_ptr] = 1'b0;
    if (w_row_ok)  w_full_nxt[w_wr_sel] = 1'b1;
    w_out_nxt = r_outstanding;
    if (w_row_ok) w_out_nxt = 1'b0;
    if (w_out_hs) w_out_nxt = 1'b1;
  end

  assign w_pop_nxt = {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};

  // Evaluated on next-state values so a request leaves one cycle after the row that enables it.
  assign w_req_cond = ({1'b0, w_rows_nxt} + {3'b000, w_out_nxt} < 4'(ROWS_PER_TS))
                      && ({1'b0, w_pop_nxt} + {2'b00, w_out_nxt} < 3'd2)
                      && (w_rows_nxt != 3'd0)
                      && !w_out_nxt;

  // NOTE: row storage has no reset; contents are only observed behind a set full bit.
  always_ff @(posedge clk) begin
    if (w_row_ok) r_slot[w_wr_sel] <= pkt_in_data[IFMAP_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_full          <= 2'b00;
      r_wr_ptr        <= 1'b0;
      r_rows_rx       <= 3'd0;
      r_outstanding   <= 1'b0;
      r_pkt_out_valid <= 1'b0;
      r_pkt_drop      <= 1'b0;
    end else begin
      r_full        <= w_full_nxt;
      r_rows_rx     <= w_rows_nxt;
      r_outstanding <= w_out_nxt;
      r_pkt_drop    <= w_in_hs & !w_row_ok;
      if (w_row_ok)               r_wr_ptr <= ~w_wr_sel;
      else if (r_state == S_DONE) r_wr_ptr <= 1'b0;
      if (!(r_pkt_out_valid && !pkt_out_ready)) r_pkt_out_valid <= w_req_cond;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= 1'b0;
      r_win_col <= 5'd0;
      r_win_row <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_full_nxt[r_rd_ptr]) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_row_end) begin
            r_rd_ptr  <= ~r_rd_ptr;
            r_win_col <= 5'd0;
            r_win_row <= r_win_row + 3'd1;
            if (r_win_row == 3'(ROWS_PER_TS - 1)) r_state <= S_DONE;
            else if (!w_full_nxt[~r_rd_ptr])      r_state <= S_IDLE;
          end else if (w_win_hs) begin
            r_win_col <= r_win_col + 5'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_rd_ptr  <= 1'b0;
          r_win_row <= 3'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign win_valid     = (r_state == S_STREAM);
  assign win_data      = win_valid ? r_slot[r_rd_ptr][r_win_col +: FILTER_SIZE] : '0;
  assign win_col       = r_win_col;
  assign win_row       = r_win_row;
  assign ts_done       = (r_state == S_DONE);
  assign pkt_drop      = r_pkt_drop;
  assign pkt_out_valid = r_pkt_out_valid;
  assign pkt_out_data  = r_pkt_out_valid ? {4'(IMEM_ID), 4'(PE_ID), 25'd0} : 33'd0;

endmodule

// File: tb/tb_ppe_row_buffer.sv
// Directed bench for ppe_row_buffer: reset, streaming, prefetch requests,
// a full timestep, backpressure, malformed packets and mid-row reset.
module tb_ppe_row_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [32:0] pkt_in_data;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [32:0] pkt_out_data;
  logic        win_valid;
  logic        win_ready;
  logic [4:0]  win_data;
  logic [4:0]  win_col;
  logic [2:0]  win_row;
  logic        ts_done;
  logic        pkt_drop;

  int checks = 0;
  int errors = 0;

  localparam logic [32:0] REQ_PKT = {4'd11, 4'd5, 25'd0};

  ppe_row_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .pkt_in_data   (pkt_in_data),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .pkt_out_data  (pkt_out_data),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .win_data      (win_data),
    .win_col       (win_col),
    .win_row       (win_row),
    .ts_done       (ts_done),
    .pkt_drop      (pkt_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pkt_in_valid = 1'b0;
    pkt_in_data = '0;
    pkt_out_ready = 1'b0;
    win_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input logic [3:0] dest, input logic [3:0] op, input logic [24:0] data);
    int n = 0;
    while (!pkt_in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (pkt_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: pkt_in_ready=%b want 1", pkt_in_ready);
    end
    pkt_in_valid = 1'b1;
    pkt_in_data  = {dest, op, data};
    tick();
    pkt_in_valid = 1'b0;
    pkt_in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pkt_in_valid = 1'b0;
    pkt_in_data = '0;
    pkt_out_ready = 1'b0;
    win_ready = 1'b0;
    #1;
    checks++;
    if ({pkt_in_ready, pkt_out_valid, win_valid, ts_done, pkt_drop} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: rdy/oval/wval/ts/drop=%b want 10000",
               {pkt_in_ready, pkt_out_valid, win_valid, ts_done, pkt_drop});
    end
    checks++;
    if (pkt_out_data !== 33'd0 || win_data !== 5'd0 || win_col !== 5'd0 || win_row !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: odata=%h wdata=%b col=%0d row=%0d want all 0",
               pkt_out_data, win_data, win_col, win_row);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_row();
    do_reset();
    send_pkt(4'd5, 4'd1, 25'h1FFFFFF);
    checks++;
    if (pkt_out_valid !== 1'b1 || pkt_out_data !== REQ_PKT) begin
      errors++;
      $display("FAIL req_issue: valid=%b data=%h want 1 %h", pkt_out_valid, pkt_out_data, REQ_PKT);
    end
    checks++;
    if (win_valid !== 1'b1 || win_col !== 5'd0) begin
      errors++;
      $display("FAIL first_window_latency: valid=%b col=%0d want 1 0", win_valid, win_col);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pkt_out_valid !== 1'b1 || pkt_out_data !== REQ_PKT || win_col !== 5'd0) begin
        errors++;
        $display("FAIL req_hold: valid=%b data=%h col=%0d want 1 %h 0",
                 pkt_out_valid, pkt_out_data, win_col, REQ_PKT);
      end
    end
    pkt_out_ready = 1'b1;
    tick();
    pkt_out_ready = 1'b0;
    checks++;
    if (pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_after_hs: valid=%b want 0", pkt_out_valid);
    end
    win_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (win_valid !== 1'b1 || win_data !== 5'b11111 || win_col !== 5'(i) || win_row !== 3'd0) begin
        errors++;
        $display("FAIL ones_window: valid=%b data=%b col=%0d row=%0d want 1 11111 %0d 0",
                 win_valid, win_data, win_col, win_row, i);
      end
      tick();
    end
    checks++;
    if (win_valid !== 1'b0 || pkt_out_valid !== 1'b0 || win_col !== 5'd0 || win_row !== 3'd1) begin
      errors++;
      $display("FAIL row_end_state: wval=%b oval=%b col=%0d row=%0d want 0 0 0 1",
               win_valid, pkt_out_valid, win_col, win_row);
    end
    win_ready = 1'b0;
  endtask

  task automatic test_one_hot();
    do_reset();
    win_ready = 1'b1;
    pkt_out_ready = 1'b1;
    send_pkt(4'd5, 4'd1, 25'h0000001);
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (win_valid !== 1'b1 || win_data !== ((i == 0) ? 5'b00001 : 5'b00000) || win_col !== 5'(i)) begin
        errors++;
        $display("FAIL onehot_window: valid=%b data=%b col=%0d want 1 %b %0d",
                 win_valid, win_data, win_col, (i == 0) ? 5'b00001 : 5'b00000, i);
      end
      tick();
    end
    win_ready = 1'b0;
  endtask

  task automatic test_full_timestep();
    logic [24:0] rows [5];
    logic [24:0] cur;
    int sent, resp, reqs, wins, tsd, drops, last_win, tsd_cyc, exp_row, exp_col;
    rows[0] = 25'h1555555;
    rows[1] = 25'h0AAAAAA;
    rows[2] = 25'h1C3C3C3;
    rows[3] = 25'h0123456;
    rows[4] = 25'h1FEDCBA;
    do_reset();
    win_ready = 1'b1;
    pkt_out_ready = 1'b1;
    send_pkt(4'd5, 4'd1, rows[0]);
    sent = 1; resp = 0; reqs = 0; wins = 0; tsd = 0; drops = 0;
    last_win = -1; tsd_cyc = -1; exp_row = 0; exp_col = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (win_valid) begin
        if (exp_row < 5) begin
          cur = rows[exp_row];
          checks++;
          if (win_row !== 3'(exp_row) || win_col !== 5'(exp_col) || win_data !== cur[exp_col +: 5]) begin
            errors++;
            $display("FAIL ts_window: row=%0d col=%0d data=%b want %0d %0d %b",
                     win_row, win_col, win_data, exp_row, exp_col, cur[exp_col +: 5]);
          end
        end
        wins++;
        last_win = cyc;
        exp_col++;
        if (exp_col == 21) begin
          exp_col = 0;
          exp_row++;
        end
      end
      if (ts_done) begin
        tsd++;
        tsd_cyc = cyc;
      end
      if (pkt_drop) drops++;
      // Memory answers one cycle after seeing the request.
      if (resp > 0 && sent < 5 && pkt_in_ready) begin
        pkt_in_valid = 1'b1;
        pkt_in_data  = {4'd5, 4'd1, rows[sent]};
        sent++;
        resp--;
      end else begin
        pkt_in_valid = 1'b0;
      end
      if (pkt_out_valid) begin
        reqs++;
        resp++;
      end
      tick();
    end
    pkt_in_valid = 1'b0;
    checks++;
    if (reqs !== 4) begin errors++; $display("FAIL ts_requests: got %0d want 4", reqs); end
    checks++;
    if (wins !== 105) begin errors++; $display("FAIL ts_windows: got %0d want 105", wins); end
    checks++;
    if (tsd !== 1 || tsd_cyc !== last_win + 1) begin
      errors++;
      $display("FAIL ts_done_pulse: count=%0d cycle=%0d want 1 at %0d", tsd, tsd_cyc, last_win + 1);
    end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL ts_drops: got %0d want 0", drops); end
    send_pkt(4'd5, 4'd1, rows[1]);
    checks++;
    if (win_valid !== 1'b1 || win_row !== 3'd0 || win_col !== 5'd0 || win_data !== 5'b01010
        || pkt_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ts2_restart: wval=%b row=%0d col=%0d data=%b oval=%b want 1 0 0 01010 1",
               win_valid, win_row, win_col, win_data, pkt_out_valid);
    end
    win_ready = 1'b0;
    pkt_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    pkt_out_ready = 1'b1;
    send_pkt(4'd5, 4'd1, 25'h0000015);
    checks++;
    if (pkt_out_valid !== 1'b1) begin errors++; $display("FAIL bp_req: got %b want 1", pkt_out_valid); end
    tick();
    send_pkt(4'd5, 4'd1, 25'h1FFFFE0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pkt_in_ready !== 1'b0 || pkt_out_valid !== 1'b0 || win_valid !== 1'b1
          || win_data !== 5'b10101 || win_col !== 5'd0) begin
        errors++;
        $display("FAIL bp_hold: rdy=%b oval=%b wval=%b data=%b col=%0d want 0 0 1 10101 0",
                 pkt_in_ready, pkt_out_valid, win_valid, win_data, win_col);
      end
      tick();
    end
    pkt_out_ready = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    win_ready = 1'b1;
    send_pkt(4'd6, 4'd1, 25'h1FFFFFF);
    checks++;
    if (pkt_drop !== 1'b1 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_dest: drop=%b wval=%b want 1 0", pkt_drop, win_valid);
    end
    tick();
    checks++;
    if (pkt_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_len: got %b want 0", pkt_drop); end
    send_pkt(4'd5, 4'd5, 25'h1FFFFFF);
    checks++;
    if (pkt_drop !== 1'b1 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_opcode: drop=%b wval=%b want 1 0", pkt_drop, win_valid);
    end
    tick();
    checks++;
    if (pkt_drop !== 1'b0 || win_valid !== 1'b0 || pkt_out_valid !== 1'b0 || pkt_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_no_state: drop=%b wval=%b oval=%b rdy=%b want 0 0 0 1",
               pkt_drop, win_valid, pkt_out_valid, pkt_in_ready);
    end
    win_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    win_ready = 1'b1;
    send_pkt(4'd5, 4'd1, 25'h1FFFFFF);
    repeat (7) tick();
    checks++;
    if (win_col !== 5'd7 || pkt_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_progress: col=%0d oval=%b want 7 1", win_col, pkt_out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0 || pkt_out_valid !== 1'b0 || win_col !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: wval=%b oval=%b col=%0d want 0 0 0", win_valid, pkt_out_valid, win_col);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (pkt_out_valid !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_request: oval=%b wval=%b want 0 0", pkt_out_valid, win_valid);
    end
    send_pkt(4'd5, 4'd1, 25'h0000003);
    checks++;
    if (win_valid !== 1'b1 || win_col !== 5'd0 || win_row !== 3'd0 || win_data !== 5'b00011
        || pkt_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_row: wval=%b col=%0d row=%0d data=%b oval=%b want 1 0 0 00011 1",
               win_valid, win_col, win_row, win_data, pkt_out_valid);
    end
    win_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_one_hot();
    test_full_timestep();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
